// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions.
// Holds the register-file geometry, the hardwired-zero register index and
// the last-write record type consumed by the EX-stage forwarding unit.
package mips_pkg;

  localparam int DW   = 32;
  localparam int AW   = 5;
  localparam int NREG = 32;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // Record of the most recent committed register write.
  typedef struct packed {
    logic          valid;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wb_rec_t;

endpackage

// File: rtl/regbank_2r1w.sv
// Register storage with one write port and two asynchronous read ports.
// No bypass and no zero guard: the caller never writes index 0 and masks
// reads of index 0 itself.
// Ports:
//   clk, rst          clock and synchronous active-high clear of all entries
//   we, waddr, wdata  write port, takes effect at the rising edge
//   raddr_a, rdata_a  read port A (combinational)
//   raddr_b, rdata_b  read port B (combinational)
module regbank_2r1w
  import mips_pkg::*;
#(
  parameter int NREG_P = NREG,
  parameter int DW_P   = DW,
  parameter int AW_P   = AW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            we,
  input  logic [AW_P-1:0] waddr,
  input  logic [DW_P-1:0] wdata,
  input  logic [AW_P-1:0] raddr_a,
  input  logic [AW_P-1:0] raddr_b,
  output logic [DW_P-1:0] rdata_a,
  output logic [DW_P-1:0] rdata_b
);

  logic [DW_P-1:0] regs_q [NREG_P];
  logic [DW_P-1:0] regs_d [NREG_P];

  // Next contents of the array: at most one entry replaced per cycle.
  always_comb begin
    regs_d = regs_q;
    if (we) begin
      regs_d[waddr] = wdata;
    end else begin
      regs_d[waddr] = regs_q[waddr];
    end
  end

  // Storage update with synchronous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      regs_q <= '{default: '0};
    end else begin
      regs_q <= regs_d;
    end
  end

  assign rdata_a = regs_q[raddr_a];
  assign rdata_b = regs_q[raddr_b];

endmodule

// File: rtl/wb_regfile.sv
// Write-back stage plus architectural register file.
// Selects the write-back value from MEM/WB, commits it to the register bank,
// serves two ID read ports with same-cycle write-through bypass, and keeps a
// one-cycle record of the last committed write plus a commit counter.
// Ports:
//   clk_WB, rst_WB               clock, synchronous active-high reset
//   data_WB_IN, resALU_WB_IN     memory / ALU candidates for write-back
//   mux2Output_WB_IN             destination register
//   RegWrite_WB_IN               write enable
//   MemtoReg_WB_IN               1 = memory data, 0 = ALU result
//   rs_WB, rt_WB                 read addresses
//   rsData_WB, rtData_WB         read data (combinational, bypassed)
//   wbData_WB                    selected write-back data (combinational)
//   lastValid_WB/Addr/Data       registered record of last cycle's commit
//   wrCount_WB                   registered count of commits (wraps)
module wb_regfile
  import mips_pkg::*;
(
  input  logic          clk_WB,
  input  logic          rst_WB,
  input  logic [DW-1:0] data_WB_IN,
  input  logic [DW-1:0] resALU_WB_IN,
  input  logic [AW-1:0] mux2Output_WB_IN,
  input  logic          RegWrite_WB_IN,
  input  logic          MemtoReg_WB_IN,
  input  logic [AW-1:0] rs_WB,
  input  logic [AW-1:0] rt_WB,
  output logic [DW-1:0] rsData_WB,
  output logic [DW-1:0] rtData_WB,
  output logic [DW-1:0] wbData_WB,
  output logic          lastValid_WB,
  output logic [AW-1:0] lastAddr_WB,
  output logic [DW-1:0] lastData_WB,
  output logic [31:0]   wrCount_WB
);

  logic          commit;
  logic [DW-1:0] wb_data;
  logic [DW-1:0] bank_rs;
  logic [DW-1:0] bank_rt;
  logic [DW-1:0] rs_data;
  logic [DW-1:0] rt_data;

  wb_rec_t       last_q;
  wb_rec_t       last_d;
  logic [31:0]   wr_count_q;
  logic [31:0]   wr_count_d;

  // Write-back select and commit qualification; reset suppresses commit,
  // which also disables the bypass during reset.
  always_comb begin
    if (MemtoReg_WB_IN) begin
      wb_data = data_WB_IN;
    end else begin
      wb_data = resALU_WB_IN;
    end
    commit = RegWrite_WB_IN && (mux2Output_WB_IN != REG_ZERO) && !rst_WB;
  end

  regbank_2r1w #(
    .NREG_P(NREG),
    .DW_P  (DW),
    .AW_P  (AW)
  ) u_bank (
    .clk    (clk_WB),
    .rst    (rst_WB),
    .we     (commit),
    .waddr  (mux2Output_WB_IN),
    .wdata  (wb_data),
    .raddr_a(rs_WB),
    .raddr_b(rt_WB),
    .rdata_a(bank_rs),
    .rdata_b(bank_rt)
  );

  // Read port A: zero guard first, then bypass, then stored value.
  always_comb begin
    rs_data = bank_rs;
    if (rs_WB == REG_ZERO) begin
      rs_data = '0;
    end else if (commit && (rs_WB == mux2Output_WB_IN)) begin
      rs_data = wb_data;
    end else begin
      rs_data = bank_rs;
    end
  end

  // Read port B: same priority as port A, evaluated independently.
  always_comb begin
    rt_data = bank_rt;
    if (rt_WB == REG_ZERO) begin
      rt_data = '0;
    end else if (commit && (rt_WB == mux2Output_WB_IN)) begin
      rt_data = wb_data;
    end else begin
      rt_data = bank_rt;
    end
  end

  // Next last-write record and counter; address/data hold when idle.
  always_comb begin
    last_d       = last_q;
    last_d.valid = commit;
    wr_count_d   = wr_count_q;
    if (commit) begin
      last_d.addr = mux2Output_WB_IN;
      last_d.data = wb_data;
      wr_count_d  = wr_count_q + 32'd1;
    end else begin
      last_d.addr = last_q.addr;
      last_d.data = last_q.data;
      wr_count_d  = wr_count_q;
    end
  end

  // Registered record and counter with synchronous reset.
  always_ff @(posedge clk_WB) begin
    if (rst_WB) begin
      last_q     <= '0;
      wr_count_q <= 32'd0;
    end else begin
      last_q     <= last_d;
      wr_count_q <= wr_count_d;
    end
  end

  assign rsData_WB    = rs_data;
  assign rtData_WB    = rt_data;
  assign wbData_WB    = wb_data;
  assign lastValid_WB = last_q.valid;
  assign lastAddr_WB  = last_q.addr;
  assign lastData_WB  = last_q.data;
  assign wrCount_WB   = wr_count_q;

endmodule

// File: tb/tb_wb_regfile.sv
module tb_wb_regfile;

  logic        clk;
  logic        rst;
  logic [31:0] dmem;
  logic [31:0] dalu;
  logic [4:0]  waddr;
  logic        rw;
  logic        mtr;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic [31:0] wb_data;
  logic        lv;
  logic [4:0]  la;
  logic [31:0] ld;
  logic [31:0] cnt;

  int total = 0;
  int bad   = 0;

  wb_regfile dut (
    .clk_WB          (clk),
    .rst_WB          (rst),
    .data_WB_IN      (dmem),
    .resALU_WB_IN    (dalu),
    .mux2Output_WB_IN(waddr),
    .RegWrite_WB_IN  (rw),
    .MemtoReg_WB_IN  (mtr),
    .rs_WB           (rs),
    .rt_WB           (rt),
    .rsData_WB       (rs_data),
    .rtData_WB       (rt_data),
    .wbData_WB       (wb_data),
    .lastValid_WB    (lv),
    .lastAddr_WB     (la),
    .lastData_WB     (ld),
    .wrCount_WB      (cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        rst;
    logic        rw;
    logic        mtr;
    logic [4:0]  addr;
    logic [31:0] dmem;
    logic [31:0] dalu;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [31:0] e_rs;
    logic [31:0] e_rt;
    logic [31:0] e_wb;
    logic        e_lv;
    logic [4:0]  e_la;
    logic [31:0] e_ld;
    logic [31:0] e_cnt;
  } vec_t;

  vec_t vt[11];

  // reference model state for the random phase
  logic [31:0] m_regs[32];
  logic        m_lv;
  logic [4:0]  m_la;
  logic [31:0] m_ld;
  logic [31:0] m_cnt;

  function automatic logic [31:0] m_read(input logic [4:0] p, input logic c,
                                         input logic [4:0] a, input logic [31:0] w);
    if (p == 5'd0) return 32'd0;
    if (c && p == a) return w;
    return m_regs[p];
  endfunction

  initial begin
    rst = 1'b1; rw = 1'b0; mtr = 1'b0; waddr = 5'd0;
    dmem = 32'd0; dalu = 32'd0; rs = 5'd0; rt = 5'd0;

    //            rst   rw    mtr   addr  dmem          dalu          rs    rt    e_rs          e_rt          e_wb          lv    la    ld            cnt
    vt[0]  = '{1'b1, 1'b0, 1'b0, 5'd0, 32'h0,        32'h0,        5'd0, 5'd0, 32'h0,        32'h0,        32'h0,        1'b0, 5'd0, 32'h0,        32'd0};
    vt[1]  = '{1'b0, 1'b1, 1'b0, 5'd5, 32'h0,        32'hDEADBEEF, 5'd5, 5'd0, 32'hDEADBEEF, 32'h0,        32'hDEADBEEF, 1'b1, 5'd5, 32'hDEADBEEF, 32'd1};
    vt[2]  = '{1'b0, 1'b0, 1'b0, 5'd0, 32'h0,        32'h0,        5'd5, 5'd9, 32'hDEADBEEF, 32'h0,        32'h0,        1'b0, 5'd5, 32'hDEADBEEF, 32'd1};
    vt[3]  = '{1'b0, 1'b1, 1'b1, 5'd9, 32'h12345678, 32'hFFFFFFFF, 5'd5, 5'd9, 32'hDEADBEEF, 32'h12345678, 32'h12345678, 1'b1, 5'd9, 32'h12345678, 32'd2};
    vt[4]  = '{1'b0, 1'b0, 1'b0, 5'd0, 32'h0,        32'h0,        5'd0, 5'd9, 32'h0,        32'h12345678, 32'h0,        1'b0, 5'd9, 32'h12345678, 32'd2};
    vt[5]  = '{1'b0, 1'b1, 1'b0, 5'd0, 32'h0,        32'hAAAA5555, 5'd0, 5'd0, 32'h0,        32'h0,        32'hAAAA5555, 1'b0, 5'd9, 32'h12345678, 32'd2};
    vt[6]  = '{1'b0, 1'b0, 1'b0, 5'd7, 32'h0,        32'h00000001, 5'd7, 5'd7, 32'h0,        32'h0,        32'h00000001, 1'b0, 5'd9, 32'h12345678, 32'd2};
    vt[7]  = '{1'b0, 1'b1, 1'b0, 5'd7, 32'h0,        32'h00000077, 5'd7, 5'd7, 32'h77,       32'h77,       32'h00000077, 1'b1, 5'd7, 32'h00000077, 32'd3};
    vt[8]  = '{1'b0, 1'b0, 1'b0, 5'd7, 32'h0,        32'h00000001, 5'd7, 5'd7, 32'h77,       32'h77,       32'h00000001, 1'b0, 5'd7, 32'h00000077, 32'd3};
    vt[9]  = '{1'b1, 1'b1, 1'b0, 5'd3, 32'h0,        32'h00000033, 5'd3, 5'd7, 32'h0,        32'h77,       32'h00000033, 1'b0, 5'd0, 32'h0,        32'd0};
    vt[10] = '{1'b0, 1'b0, 1'b0, 5'd0, 32'h0,        32'h0,        5'd3, 5'd7, 32'h0,        32'h0,        32'h0,        1'b0, 5'd0, 32'h0,        32'd0};

    // directed table
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      rst = vt[i].rst; rw = vt[i].rw; mtr = vt[i].mtr; waddr = vt[i].addr;
      dmem = vt[i].dmem; dalu = vt[i].dalu; rs = vt[i].rs; rt = vt[i].rt;
      #1;
      if (i != 0) begin
        chk($sformatf("v%0d rs", i), rs_data, vt[i].e_rs);
        chk($sformatf("v%0d rt", i), rt_data, vt[i].e_rt);
      end
      chk($sformatf("v%0d wb", i), wb_data, vt[i].e_wb);
      @(posedge clk); #1;
      chk($sformatf("v%0d lastValid", i), {31'd0, lv}, {31'd0, vt[i].e_lv});
      chk($sformatf("v%0d lastAddr", i), {27'd0, la}, {27'd0, vt[i].e_la});
      chk($sformatf("v%0d lastData", i), ld, vt[i].e_ld);
      chk($sformatf("v%0d wrCount", i), cnt, vt[i].e_cnt);
    end

    // all 32 addresses read back as zero after reset
    @(negedge clk);
    rw = 1'b0; rst = 1'b0;
    for (int a = 0; a < 32; a++) begin
      rs = a[4:0]; rt = 5'(31 - a);
      #1;
      chk($sformatf("zero rs r%0d", a), rs_data, 32'd0);
      chk($sformatf("zero rt r%0d", 31 - a), rt_data, 32'd0);
    end

    // counter wrap: preload to all-ones, then one commit
    @(negedge clk);
    force dut.wr_count_q = 32'hFFFF_FFFF;
    #1;
    release dut.wr_count_q;
    #1;
    chk("wrap preload", cnt, 32'hFFFF_FFFF);
    rw = 1'b1; mtr = 1'b0; waddr = 5'd1; dalu = 32'h0000_0005;
    @(posedge clk); #1;
    chk("wrap count", cnt, 32'd0);
    chk("wrap lastValid", {31'd0, lv}, 32'd1);

    // randomized phase against the reference model; first cycle resets
    m_cnt = 32'd0; m_lv = 1'b0; m_la = 5'd0; m_ld = 32'd0;
    for (int r = 0; r < 32; r++) m_regs[r] = 32'd0;
    for (int i = 0; i < 400; i++) begin
      logic        c;
      logic [31:0] w;
      @(negedge clk);
      rst   = (i == 0) || ($urandom_range(0, 39) == 0);
      rw    = ($urandom_range(0, 3) != 0);
      mtr   = $urandom_range(0, 1) == 1;
      waddr = 5'($urandom_range(0, 31));
      dmem  = $urandom;
      dalu  = $urandom;
      rs    = ($urandom_range(0, 2) == 0) ? waddr : 5'($urandom_range(0, 31));
      rt    = ($urandom_range(0, 2) == 0) ? waddr : 5'($urandom_range(0, 31));
      w = mtr ? dmem : dalu;
      c = rw && (waddr != 5'd0) && !rst;
      #1;
      if (i != 0) begin
        chk("rand rs", rs_data, m_read(rs, c, waddr, w));
        chk("rand rt", rt_data, m_read(rt, c, waddr, w));
      end
      chk("rand wb", wb_data, w);
      @(posedge clk);
      if (rst) begin
        for (int r = 0; r < 32; r++) m_regs[r] = 32'd0;
        m_lv = 1'b0; m_la = 5'd0; m_ld = 32'd0; m_cnt = 32'd0;
      end else if (c) begin
        m_regs[waddr] = w;
        m_lv = 1'b1; m_la = waddr; m_ld = w; m_cnt = m_cnt + 32'd1;
      end else begin
        m_lv = 1'b0;
      end
      #1;
      chk("rand lastValid", {31'd0, lv}, {31'd0, m_lv});
      chk("rand lastAddr", {27'd0, la}, {27'd0, m_la});
      chk("rand lastData", ld, m_ld);
      chk("rand wrCount", cnt, m_cnt);
    end

    // sweep the final register contents
    @(negedge clk);
    rw = 1'b0; rst = 1'b0;
    for (int a = 0; a < 32; a++) begin
      rs = a[4:0]; rt = a[4:0];
      #1;
      chk($sformatf("final r%0d", a), rs_data, (a == 0) ? 32'd0 : m_regs[a]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
